// File: rtl/timer_arbiter_if.sv
// Bus between the timer arbiter, its four requesters and the shared prog_timer.
// Handshake: requester i raises req[i] and holds it (level) until it sees done[i] or abandons;
// grant[i] marks ownership; tmr_start, tmr_zero and done are single-cycle pulses.
interface timer_arbiter_if #(parameter int WIDTH = 24) ();
  logic [3:0]         req;
  logic [4*WIDTH-1:0] period;
  logic [3:0]         grant;
  logic [3:0]         done;
  logic               busy;
  logic               tmr_start;
  logic [WIDTH-1:0]   tmr_load;
  logic               tmr_en;
  logic               tmr_zero;

  modport master (output req, period, tmr_zero,
                  input  grant, done, busy, tmr_start, tmr_load, tmr_en);
  modport slave  (input  req, period, tmr_zero,
                  output grant, done, busy, tmr_start, tmr_load, tmr_en);
endinterface

// File: rtl/timer_arbiter.sv
// Arbitrates four requesters for one shared prog_timer (IDLE/LOAD/RUN/DONE).
// Selection is round-robin; define TIMER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module timer_arbiter #(
  parameter int WIDTH = 24
) (
  input  logic           clk,
  input  logic           reset,
  timer_arbiter_if.slave bus,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       win_id;
  logic [WIDTH-1:0] win_period;
`ifndef TIMER_ARB_FIXED_PRIO_EN
  logic [1:0]       last_id;
  logic [1:0]       cand;
`endif

  always_comb begin
    win_id = 2'd0;
`ifdef TIMER_ARB_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) win_id = 2'(i);
    end
`else
    cand = 2'd0;
    // Walk offsets farthest-first so the nearest requester after last_id wins.
    for (int k = 3; k >= 0; k--) begin
      cand = last_id + 2'(k + 1);
      if (bus.req[cand]) win_id = cand;
    end
`endif
    win_period = '0;
    for (int i = 0; i < 4; i++) begin
      if (win_id == 2'(i)) win_period = bus.period[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bus.grant     <= '0;
      bus.done      <= '0;
      bus.tmr_start <= 1'b0;
      bus.tmr_en    <= 1'b0;
      bus.tmr_load  <= '0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
      last_id       <= 2'd3;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state         <= LOAD;
            bus.grant     <= 4'b0001 << win_id;
            bus.tmr_load  <= win_period;
            bus.tmr_start <= |win_period;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            last_id       <= win_id;
`endif
          end
        end
        LOAD: begin
          bus.tmr_start <= 1'b0;
          // A zero period never starts the timer and completes straight away.
          if (bus.tmr_load == '0) begin
            state    <= DONE;
            bus.done <= bus.grant;
          end else begin
            state      <= RUN;
            bus.tmr_en <= 1'b1;
          end
        end
        RUN: begin
          if (!(|(bus.req & bus.grant))) begin
            state      <= IDLE;
            bus.grant  <= '0;
            bus.tmr_en <= 1'b0;
          end else if (bus.tmr_zero) begin
            state      <= DONE;
            bus.done   <= bus.grant;
            bus.tmr_en <= 1'b0;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.done  <= '0;
          bus.grant <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed self-checking bench for timer_arbiter with a behavioural prog_timer model.
module tb_timer_arbiter;
  localparam int WIDTH = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  state_dbg;
  logic        model_zero = 1'b0;
  logic        inj_zero;
  int unsigned cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [3:0]  exp_rr[5];

  timer_arbiter_if #(.WIDTH(WIDTH)) bus ();

  timer_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Timer model: tmr_zero pulses tmr_load enabled cycles after the tmr_start cycle.
  assign bus.tmr_zero = model_zero | inj_zero;

  always @(negedge clk) begin
    model_zero = 1'b0;
    if (cnt != 0 && bus.tmr_en) begin
      cnt = cnt - 1;
      if (cnt == 0) model_zero = 1'b1;
    end
    if (bus.tmr_start) cnt = bus.tmr_load;
    else if (!bus.tmr_en) cnt = 0;
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_period(input int idx, input logic [WIDTH-1:0] val);
    bus.period[idx*WIDTH +: WIDTH] = val;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef TIMER_ARB_FIXED_PRIO_EN
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0001; exp_rr[2] = 4'b0001;
    exp_rr[3] = 4'b0001; exp_rr[4] = 4'b0001;
`else
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
`endif
    reset    = 1'b0;
    bus.req  = '0;
    bus.period = '0;
    inj_zero = 1'b0;
    repeat (3) tick();

    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.tmr_start, 0);
    chk("rst_en", bus.tmr_en, 0);
    chk("rst_load", bus.tmr_load, 0);
    chk("rst_state", state_dbg, 0);
    reset = 1'b1;
    tick();

    // Single request, period 5
    set_period(0, 5);
    bus.req = 4'b0001;
    tick();
    chk("t1_grant", bus.grant, 4'b0001);
    chk("t1_start", bus.tmr_start, 1);
    chk("t1_load", bus.tmr_load, 5);
    chk("t1_busy", bus.busy, 1);
    chk("t1_en_load", bus.tmr_en, 0);
    tick();
    chk("t1_start_off", bus.tmr_start, 0);
    chk("t1_en_run", bus.tmr_en, 1);
    chk("t1_state_run", state_dbg, 2);
    repeat (4) tick();
    chk("t1_done_early", bus.done, 0);
    chk("t1_en_late", bus.tmr_en, 1);
    tick();
    chk("t1_done", bus.done, 4'b0001);
    chk("t1_grant_held", bus.grant, 4'b0001);
    chk("t1_en_done", bus.tmr_en, 0);
    bus.req = 4'b0000;
    tick();
    chk("t1_done_clr", bus.done, 0);
    chk("t1_grant_clr", bus.grant, 0);
    chk("t1_busy_clr", bus.busy, 0);

    // Fairness with all four requesting, from a fresh reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_period(i, 3);
    bus.req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("rr_grant%0d", n), bus.grant, exp_rr[n]);
      chk($sformatf("rr_start%0d", n), bus.tmr_start, 1);
      chk($sformatf("rr_load%0d", n), bus.tmr_load, 3);
      repeat (4) tick();
      chk($sformatf("rr_done%0d", n), bus.done, exp_rr[n]);
      tick();
      chk($sformatf("rr_gap%0d", n), bus.grant, 0);
      if (n == 4) bus.req = 4'b0000;
      tick();
    end
    chk("rr_idle", state_dbg, 0);

    // Zero period skips RUN and never strobes the timer
    set_period(2, 0);
    bus.req = 4'b0100;
    tick();
    chk("z_grant", bus.grant, 4'b0100);
    chk("z_start_load", bus.tmr_start, 0);
    chk("z_state_load", state_dbg, 1);
    tick();
    chk("z_done", bus.done, 4'b0100);
    chk("z_start_done", bus.tmr_start, 0);
    chk("z_en", bus.tmr_en, 0);
    bus.req = 4'b0000;
    tick();
    chk("z_done_clr", bus.done, 0);
    chk("z_grant_clr", bus.grant, 0);
    inj_zero = 1'b1;
    tick();
    inj_zero = 1'b0;
    chk("stray_zero_state", state_dbg, 0);
    chk("stray_zero_done", bus.done, 0);

    // Abandon during RUN
    set_period(1, 1000);
    bus.req = 4'b0010;
    tick();
    chk("ab_grant", bus.grant, 4'b0010);
    tick();
    repeat (9) tick();
    chk("ab_en_run", bus.tmr_en, 1);
    chk("ab_state_run", state_dbg, 2);
    bus.req = 4'b0000;
    tick();
    chk("ab_grant_clr", bus.grant, 0);
    chk("ab_en_clr", bus.tmr_en, 0);
    chk("ab_done", bus.done, 0);
    chk("ab_busy", bus.busy, 0);
    tick();
    chk("ab_done_later", bus.done, 0);

    // Period changes during ownership are ignored
    set_period(0, 5);
    bus.req = 4'b0001;
    tick();
    chk("pc_load", bus.tmr_load, 5);
    tick();
    set_period(0, 9);
    repeat (2) tick();
    chk("pc_load_held", bus.tmr_load, 5);
    repeat (2) tick();
    chk("pc_done_early", bus.done, 0);
    tick();
    chk("pc_done", bus.done, 4'b0001);
    chk("pc_load_done", bus.tmr_load, 5);
    bus.req = 4'b0000;
    tick();

    // Asynchronous reset in the middle of RUN
    set_period(3, 50);
    bus.req = 4'b1000;
    tick();
    chk("ar_grant", bus.grant, 4'b1000);
    tick();
    tick();
    chk("ar_en_run", bus.tmr_en, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_grant_clr", bus.grant, 0);
    chk("ar_done", bus.done, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_en", bus.tmr_en, 0);
    chk("ar_start", bus.tmr_start, 0);
    chk("ar_load", bus.tmr_load, 0);
    chk("ar_state", state_dbg, 0);
    tick();
    set_period(0, 5);
    bus.req = 4'b1001;
    reset = 1'b1;
    tick();
    chk("ar_first_grant", bus.grant, 4'b0001);
    chk("ar_first_load", bus.tmr_load, 5);
    chk("ar_done_after", bus.done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter: WIDTH, 24, bit width of timer load value and of each period field.
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  4  per-requester timer request, level, held until done or abandoned.
REQ-005 Port: period  input  4*WIDTH  packed periods, requester i at bits [i*WIDTH +: WIDTH].
REQ-006 Port: grant  output  4  one-hot owner of the shared timer, all-zero when unowned.
REQ-007 Port: done  output  4  one-cycle completion pulse to the owning requester.
REQ-008 Port: busy  output  1  high in every state except IDLE.
REQ-009 Port: tmr_start  output  1  one-cycle load strobe to the shared prog_timer.
REQ-010 Port: tmr_load  output  WIDTH  latched period presented to the timer.
REQ-011 Port: tmr_en  output  1  timer count enable.
REQ-012 Port: tmr_zero  input  1  timer expiry pulse.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, RUN, DONE, one state register.
REQ-014 IDLE: any req bit high at a clock edge SHALL select a winner, set grant, latch its period into tmr_load, and move to LOAD.
REQ-015 Winner selection SHALL be round-robin: search starts at (last_id+1) mod 4, last_id updated on each entry to LOAD.
REQ-016 LOAD: tmr_start=1 for exactly this one cycle, then RUN; if latched period is 0, tmr_start SHALL stay 0 and next state is DONE.
REQ-017 RUN: tmr_en=1; tmr_zero high at an edge SHALL move to DONE; tmr_zero in any other state SHALL be ignored.
REQ-018 RUN: req of the granted requester low at an edge SHALL abort: next state IDLE, grant cleared, tmr_en low, no done pulse.
REQ-019 DONE: done[id]=1 for exactly one cycle, grant still held, tmr_en=0; next state IDLE unconditionally.
REQ-020 grant SHALL be cleared on leaving DONE; minimum one IDLE cycle between consecutive ownerships.
REQ-021 tmr_load SHALL hold its value from LOAD through DONE; changes on period during ownership SHALL be ignored.
REQ-022 At most one bit of grant and of done SHALL ever be high.
REQ-023 Latency: tmr_zero sampled at edge N SHALL give done high in the cycle following edge N.

Reset
REQ-024 reset low SHALL immediately force state IDLE, grant=0, done=0, busy=0, tmr_start=0, tmr_en=0, tmr_load=0, last_id=3.
REQ-025 Reset asserted mid-RUN SHALL drop tmr_en asynchronously with no done pulse; first grant after release goes to requester 0 when requested.

Configuration
REQ-026 Macro TIMER_ARB_FIXED_PRIO_EN defined: selection SHALL be fixed priority, lowest index wins, last_id unused.
REQ-027 Macro TIMER_ARB_FIXED_PRIO_EN undefined: selection SHALL be round-robin per REQ-015.

Verification
REQ-028 Bench timer model pulses tmr_zero 5 cycles after tmr_start; req=0001, period0=5 -> grant=0001 next cycle, tmr_start one cycle with tmr_load=5, done=0001 cycle after tmr_zero, then grant=0000.
REQ-029 req=1111 held, all periods 3 -> grants in order 0001,0010,0100,1000,0001; with TIMER_ARB_FIXED_PRIO_EN -> 0001 every time.
REQ-030 req=0100, period2=0 -> LOAD then DONE, tmr_start never high, done=0100 on cycle 3 after req sampled.
REQ-031 req=0010, period1=1000, drop req in RUN cycle 10 -> next cycle grant=0000, tmr_en=0, done stays 0000.
REQ-032 reset low during RUN with grant=1000 -> all outputs 0 immediately; after release req=1001 -> grant=0001.
REQ-033 Change period0 from 5 to 9 during RUN -> tmr_load stays 5, done timing unchanged.
